// File: rtl/auto_guesser.sv
// auto_guesser: automatic player for the 1A2B game.
// It issues 4-digit guesses with distinct digits and reads the game core's
// A/B feedback. Each new guess is the lowest candidate that agrees with
// every stored (guess, A, B) entry in the history.
//
// Ports:
//   clka            system clock, rising edge
//   reset           asynchronous active-low reset
//   restart         synchronous clear back to IDLE, accepted in any state
//   start           begin a game (sampled in IDLE only)
//   Anum, Bnum      feedback counts from the game core
//   valid           feedback strobe (sampled in WAIT only)
//   guess0..guess3  registered guess digits, guess0 is the leftmost digit
//   enter           one-cycle pulse, guess outputs are valid while it is high
//   busy            high while searching, issuing or waiting for feedback
//   done            last response was 4A
//   fail            no consistent candidate left, or guess limit reached
//   guess_cnt       guesses issued in the current game
//
// Optional feature: define FEEDBACK_CHECK_EN to reject impossible responses
// (Anum>4, Anum+Bnum>4, or 3A1B) by going straight to FAIL.

module auto_guesser #(
    parameter int unsigned MAX_GUESS  = 10,
    parameter logic [15:0] START_CAND = 16'h0123
) (
    input  logic       clka,
    input  logic       reset,
    input  logic       restart,
    input  logic       start,
    input  logic [2:0] Anum,
    input  logic [2:0] Bnum,
    input  logic       valid,
    output logic [3:0] guess0,
    output logic [3:0] guess1,
    output logic [3:0] guess2,
    output logic [3:0] guess3,
    output logic       enter,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] guess_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEARCH = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;

    localparam logic [3:0] MAX_CNT = MAX_GUESS[3:0];

    logic [2:0]  state;
    logic [15:0] cand;
    logic [3:0]  idx;
    logic [3:0]  hist_cnt;

    logic [15:0] hist_g [MAX_GUESS];
    logic [2:0]  hist_a [MAX_GUESS];
    logic [2:0]  hist_b [MAX_GUESS];

    logic [3:0]  cd [4];
    logic [3:0]  hd [4];
    logic        dup;
    logic [2:0]  sa;
    logic [2:0]  sb;
    logic        match;
    logic [15:0] inc_val;
    logic        inc_ovf;
    logic        fb_bad;
    logic        hist_we;

    // Candidate digits, duplicate detection, score against history[idx],
    // and the BCD increment (guess3 nibble is least significant).
    always_comb begin
        logic carry;
        for (int unsigned i = 0; i < 4; i++) begin
            cd[i] = cand[4*(3-i) +: 4];
            hd[i] = hist_g[idx][4*(3-i) +: 4];
        end

        dup = 1'b0;
        for (int unsigned i = 0; i < 4; i++)
            for (int unsigned j = i + 1; j < 4; j++)
                if (cd[i] == cd[j]) dup = 1'b1;

        sa = '0;
        sb = '0;
        for (int unsigned i = 0; i < 4; i++)
            for (int unsigned j = 0; j < 4; j++)
                if (cd[i] == hd[j]) begin
                    if (i == j) sa = sa + 3'd1;
                    else        sb = sb + 3'd1;
                end
        match = (sa == hist_a[idx]) && (sb == hist_b[idx]);

        carry   = 1'b1;
        inc_val = cand;
        for (int unsigned i = 0; i < 4; i++)
            if (carry) begin
                if (cand[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = cand[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        inc_ovf = carry;
    end

`ifdef FEEDBACK_CHECK_EN
    logic [3:0] fb_sum;
    assign fb_sum = {1'b0, Anum} + {1'b0, Bnum};
    assign fb_bad = (Anum > 3'd4) || (fb_sum > 4'd4) || (Anum == 3'd3 && Bnum == 3'd1);
`else
    assign fb_bad = 1'b0;
`endif

    assign hist_we = reset && !restart && (state == S_WAIT) && valid &&
                     (Anum != 3'd4) && !fb_bad;

    // History storage carries no reset; hist_cnt alone marks live entries.
    // cand still holds the issued guess while in WAIT.
    always_ff @(posedge clka) begin
        if (hist_we) begin
            hist_g[hist_cnt] <= cand;
            hist_a[hist_cnt] <= Anum;
            hist_b[hist_cnt] <= Bnum;
        end
    end

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cand      <= START_CAND;
            idx       <= '0;
            hist_cnt  <= '0;
            guess0    <= '0;
            guess1    <= '0;
            guess2    <= '0;
            guess3    <= '0;
            enter     <= 1'b0;
            guess_cnt <= '0;
        end else if (restart) begin
            state     <= S_IDLE;
            cand      <= START_CAND;
            idx       <= '0;
            hist_cnt  <= '0;
            guess0    <= '0;
            guess1    <= '0;
            guess2    <= '0;
            guess3    <= '0;
            enter     <= 1'b0;
            guess_cnt <= '0;
        end else begin
            enter <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cand      <= START_CAND;
                        idx       <= '0;
                        hist_cnt  <= '0;
                        guess_cnt <= '0;
                        state     <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (dup || (idx != hist_cnt && !match)) begin
                        if (inc_ovf) state <= S_FAIL;
                        else         cand  <= inc_val;
                        idx <= '0;
                    end else if (idx == hist_cnt) begin
                        state <= S_ISSUE;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                S_ISSUE: begin
                    guess0    <= cd[0];
                    guess1    <= cd[1];
                    guess2    <= cd[2];
                    guess3    <= cd[3];
                    enter     <= 1'b1;
                    guess_cnt <= guess_cnt + 4'd1;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (valid) begin
                        if (fb_bad) begin
                            state <= S_FAIL;
                        end else if (Anum == 3'd4) begin
                            state <= S_DONE;
                        end else begin
                            hist_cnt <= hist_cnt + 4'd1;
                            idx      <= '0;
                            if (hist_cnt + 4'd1 == MAX_CNT) begin
                                state <= S_FAIL;
                            end else if (inc_ovf) begin
                                state <= S_FAIL;
                            end else begin
                                cand  <= inc_val;
                                state <= S_SEARCH;
                            end
                        end
                    end
                end
                S_DONE:  state <= S_DONE;
                S_FAIL:  state <= S_FAIL;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_SEARCH) || (state == S_ISSUE) || (state == S_WAIT);
    assign done = (state == S_DONE);
    assign fail = (state == S_FAIL);

endmodule

// File: tb/tb_auto_guesser.sv
// Scoreboard bench for auto_guesser. A reference player computes the whole
// expected guess sequence of a game from the game rules (lowest distinct-digit
// number consistent with all recorded responses) and queues it; a monitor
// compares each enter pulse against the queue.

module tb_auto_guesser;

    localparam int START_VAL = 123;
    localparam int MAXG      = 10;
    localparam int BUDGET    = 30000;

    logic       clka = 1'b0;
    logic       reset = 1'b0;
    logic       restart = 1'b0;
    logic       start = 1'b0;
    logic [2:0] Anum = '0;
    logic [2:0] Bnum = '0;
    logic       valid = 1'b0;
    logic [3:0] guess0, guess1, guess2, guess3;
    logic       enter, busy, done, fail;
    logic [3:0] guess_cnt;

    always #5 clka = ~clka;

    auto_guesser #(.MAX_GUESS(MAXG), .START_CAND(16'h0123)) dut (
        .clka(clka), .reset(reset), .restart(restart), .start(start),
        .Anum(Anum), .Bnum(Bnum), .valid(valid),
        .guess0(guess0), .guess1(guess1), .guess2(guess2), .guess3(guess3),
        .enter(enter), .busy(busy), .done(done), .fail(fail),
        .guess_cnt(guess_cnt)
    );

    typedef struct {
        logic [15:0] g;
        int          cnt;
    } exp_t;

    exp_t exp_q[$];
    int   post_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // reference model history
    int m_g[$];
    int m_a[$];
    int m_b[$];

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int dig(input int v, input int pos);
        int d = v;
        for (int k = 0; k < 3 - pos; k++) d = d / 10;
        return d % 10;
    endfunction

    function automatic bit distinct(input int v);
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (dig(v, i) == dig(v, j)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void score(input int g, input int s, output int a, output int b);
        a = 0;
        b = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (dig(g, i) == dig(s, j)) begin
                    if (i == j) a++;
                    else        b++;
                end
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(dig(v, 0)), 4'(dig(v, 1)), 4'(dig(v, 2)), 4'(dig(v, 3))};
    endfunction

    function automatic bit bad_fb(input int a, input int b);
        return (a > 4) || (a + b > 4) || (a == 3 && b == 1);
    endfunction

    function automatic int next_guess();
        int a, b;
        bit ok;
        for (int v = START_VAL; v <= 9999; v++) begin
            if (!distinct(v)) continue;
            ok = 1'b1;
            for (int k = 0; k < m_g.size(); k++) begin
                score(v, m_g[k], a, b);
                if (a != m_a[k] || b != m_b[k]) ok = 1'b0;
            end
            if (ok) return v;
        end
        return -1;
    endfunction

    // mode 0: responder scores against secret; mode 1: fixed reply (fa, fb)
    task automatic plan_game(input int mode, input int secret, input int fa, input int fb,
                             output int e_done, output int e_fail, output int e_cnt);
        int g, a, b;
        exp_t e;
        m_g.delete(); m_a.delete(); m_b.delete();
        e_done = 0; e_fail = 0; e_cnt = 0;
        forever begin
            g = next_guess();
            if (g < 0) begin e_fail = 1; break; end
            e_cnt++;
            e.g = to_bcd(g);
            e.cnt = e_cnt;
            exp_q.push_back(e);
            if (mode == 0) score(g, secret, a, b);
            else begin a = fa; b = fb; end
`ifdef FEEDBACK_CHECK_EN
            if (bad_fb(a, b)) begin post_q.push_back(2); e_fail = 1; break; end
`endif
            if (a == 4) begin post_q.push_back(3); e_done = 1; break; end
            m_g.push_back(g); m_a.push_back(a); m_b.push_back(b);
            if (m_g.size() == MAXG) begin post_q.push_back(2); e_fail = 1; break; end
            post_q.push_back(1);
        end
    endtask

    // monitor: every enter pulse is matched against the scoreboard
    always @(negedge clka) begin
        if (reset && enter) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_enter: got guess %h%h%h%h cnt %0d, expected no enter",
                         guess0, guess1, guess2, guess3, guess_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({guess0, guess1, guess2, guess3} != e.g || int'(guess_cnt) != e.cnt) begin
                    miscompares++;
                    $display("FAIL guess: got %h%h%h%h cnt %0d, expected %h cnt %0d",
                             guess0, guess1, guess2, guess3, guess_cnt, e.g, e.cnt);
                end
            end
        end
    end

    function automatic int state_code();
        if (done) return 3;
        if (fail) return 2;
        if (busy) return 1;
        return 0;
    endfunction

    task automatic clear_and_check(input string tag);
        @(negedge clka);
        restart = 1'b1;
        @(negedge clka);
        restart = 1'b0;
        chk({tag, "_idle_state"}, state_code(), 0);
        chk({tag, "_idle_cnt"}, int'(guess_cnt), 0);
    endtask

    task automatic run_game(input int mode, input int secret, input int fa, input int fb);
        int e_done, e_fail, e_cnt, cyc, first, a, b, gv;
        bit fin, was_reply;
        plan_game(mode, secret, fa, fb, e_done, e_fail, e_cnt);
        @(negedge clka);
        start = 1'b1;
        cyc = 0; first = -1; fin = 1'b0; was_reply = 1'b0;
        while (!fin && cyc < BUDGET) begin
            @(negedge clka);
            start = 1'b0;
            cyc++;
            if (was_reply) begin
                if (post_q.size() == 0) chk("post_reply_extra", state_code(), -1);
                else chk("post_reply_state", state_code(), post_q.pop_front());
            end
            was_reply = 1'b0;
            valid = 1'b0;
            if (enter) begin
                if (first < 0) first = cyc;
                gv = guess0 * 1000 + guess1 * 100 + guess2 * 10 + int'(guess3);
                if (mode == 0) score(gv, secret, a, b);
                else begin a = fa; b = fb; end
                Anum = 3'(a);
                Bnum = 3'(b);
                valid = 1'b1;
                was_reply = 1'b1;
            end
            if (done || fail) fin = 1'b1;
        end
        valid = 1'b0;
        if (!fin) chk("game_timeout", cyc, -1);
        chk("first_enter_latency", first, 3);
        chk("end_done", int'(done), e_done);
        chk("end_fail", int'(fail), e_fail);
        chk("end_busy", int'(busy), 0);
        chk("end_guess_cnt", int'(guess_cnt), e_cnt);
        // start is ignored once the game has ended
        @(negedge clka);
        start = 1'b1;
        @(negedge clka);
        start = 1'b0;
        repeat (3) @(negedge clka);
        chk("sticky_state", state_code(), e_done ? 3 : 2);
        chk("queue_drained", exp_q.size() + post_q.size(), 0);
        exp_q.delete();
        post_q.delete();
        clear_and_check("after_game");
    endtask

    task automatic restart_in_wait();
        exp_t e;
        int cyc;
        e.g = 16'h0123;
        e.cnt = 1;
        exp_q.push_back(e);
        @(negedge clka);
        start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clka);
            start = 1'b0;
            cyc++;
        end while (!enter && cyc < 50);
        chk("restart_saw_enter", int'(enter), 1);
        restart = 1'b1;
        valid = 1'b1;
        Anum = 3'd4;
        Bnum = 3'd0;
        @(negedge clka);
        restart = 1'b0;
        valid = 1'b0;
        chk("restart_busy", int'(busy), 0);
        chk("restart_done", int'(done), 0);
        chk("restart_cnt", int'(guess_cnt), 0);
        chk("restart_enter", int'(enter), 0);
        repeat (3) @(negedge clka);
        chk("restart_idle", state_code(), 0);
        chk("restart_queue", exp_q.size(), 0);
        exp_q.delete();
    endtask

    function automatic int rand_secret();
        int v;
        do v = $urandom_range(0, 9999); while (!distinct(v));
        return v;
    endfunction

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clka);
        chk("reset_outputs", int'({guess0, guess1, guess2, guess3, enter, busy, done, fail, guess_cnt}), 0);
        reset = 1'b1;
        repeat (2) @(negedge clka);
        chk("post_reset_idle", state_code(), 0);

        run_game(0, 123, 0, 0);
        run_game(0, 4567, 0, 0);
        run_game(0, 1032, 0, 0);
        run_game(1, 0, 0, 0);
        restart_in_wait();
        run_game(1, 0, 3, 1);
        for (int n = 0; n < 3; n++) run_game(0, rand_secret(), 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
